// File: rtl/hemaia_csr_regbank.sv
// CSR slave register bank: scratch/ctrl/status registers plus host<->hw mailbox FIFOs.
// Writes complete in the request cycle; reads answer one cycle later and hold until csr_rsp_ready_i.

// Small synchronous FIFO with occupancy count; the caller qualifies push (not full) and pop (not empty).
module hemaia_csr_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];
endmodule

module hemaia_csr_regbank #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MBOX_DEPTH = 4,
    parameter logic [31:0] CTRL_RESET = 32'h0,
    parameter type csr_req_t = struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
        logic                  write;
    },
    parameter type csr_rsp_t = struct packed {
        logic [31:0] data;
    }
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  csr_req_t    csr_req_i,
    input  logic        csr_req_valid_i,
    output logic        csr_req_ready_o,
    output csr_rsp_t    csr_rsp_o,
    output logic        csr_rsp_valid_o,
    input  logic        csr_rsp_ready_i,
    output logic [31:0] ctrl_o,
    input  logic [31:0] status_i,
    output logic [31:0] mbox_out_data_o,
    output logic        mbox_out_valid_o,
    input  logic        mbox_out_ready_i,
    input  logic [31:0] mbox_in_data_i,
    input  logic        mbox_in_valid_i,
    output logic        mbox_in_ready_o,
    output logic        irq_o
);
    localparam int unsigned CW = $clog2(MBOX_DEPTH) + 1;

    localparam logic [2:0] REG_SCRATCH   = 3'd0;
    localparam logic [2:0] REG_CTRL      = 3'd1;
    localparam logic [2:0] REG_STATUS    = 3'd2;
    localparam logic [2:0] REG_MBOX      = 3'd3;
    localparam logic [2:0] REG_MBOX_STAT = 3'd4;

    typedef enum logic {IDLE, RESP} state_t;

    state_t         state_q;
    state_t         state_d;
    logic [31:0]    scratch_q;
    logic [31:0]    ctrl_q;
    logic [31:0]    rsp_q;
    logic [31:0]    rd_data;
    logic [31:0]    mbox_stat;
    logic           overflow_q;
    logic           underflow_q;
    logic           irq_q;
    logic [2:0]     reg_idx;
    logic           wr_en;
    logic           rd_en;
    logic           addr_unused;

    logic [31:0]    out_head;
    logic [CW-1:0]  out_count;
    logic           out_full;
    logic           out_empty;
    logic           out_push;
    logic           out_pop;

    logic [31:0]    in_head;
    logic [CW-1:0]  in_count;
    logic [CW-1:0]  in_count_next;
    logic           in_full;
    logic           in_empty;
    logic           in_push;
    logic           in_pop;

    logic           overflow_set;
    logic           underflow_set;
    logic           stat_wr;

    // Only addr[4:2] selects a register; the remaining address bits are don't-care.
    assign reg_idx     = csr_req_i.addr[4:2];
    assign addr_unused = ^csr_req_i.addr;

    always_comb begin
        state_d         = state_q;
        csr_req_ready_o = 1'b0;
        wr_en           = 1'b0;
        rd_en           = 1'b0;
        case (state_q)
            IDLE: begin
                wr_en           = csr_req_valid_i & csr_req_i.write;
                csr_req_ready_o = wr_en;
                if (csr_req_valid_i & ~csr_req_i.write) begin
                    rd_en   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                csr_req_ready_o = csr_rsp_ready_i;
                if (csr_req_valid_i & csr_rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    assign out_full  = (out_count == CW'(MBOX_DEPTH));
    assign out_empty = (out_count == '0);
    assign in_full   = (in_count == CW'(MBOX_DEPTH));
    assign in_empty  = (in_count == '0);

    // Fullness comes from the registered count, so a same-cycle consumer pop never rescues a push.
    assign out_push      = wr_en & (reg_idx == REG_MBOX) & ~out_full;
    assign overflow_set  = wr_en & (reg_idx == REG_MBOX) & out_full;
    assign out_pop       = mbox_out_ready_i & ~out_empty;
    assign stat_wr       = wr_en & (reg_idx == REG_MBOX_STAT);

    assign in_push       = mbox_in_valid_i & ~in_full;
    assign in_pop        = rd_en & (reg_idx == REG_MBOX) & ~in_empty;
    assign underflow_set = rd_en & (reg_idx == REG_MBOX) & in_empty;
    assign in_count_next = in_count + CW'(in_push) - CW'(in_pop);

    hemaia_csr_fifo #(
        .WIDTH (32),
        .DEPTH (MBOX_DEPTH)
    ) u_mbox_out (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (out_push),
        .push_data (csr_req_i.data),
        .pop       (out_pop),
        .head      (out_head),
        .count     (out_count)
    );

    hemaia_csr_fifo #(
        .WIDTH (32),
        .DEPTH (MBOX_DEPTH)
    ) u_mbox_in (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (in_push),
        .push_data (mbox_in_data_i),
        .pop       (in_pop),
        .head      (in_head),
        .count     (in_count)
    );

    assign mbox_stat = {14'd0, underflow_q, overflow_q, 8'(in_count), 8'(out_count)};

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            REG_SCRATCH:   rd_data = scratch_q;
            REG_CTRL:      rd_data = ctrl_q;
            REG_STATUS:    rd_data = status_i;
            REG_MBOX:      rd_data = in_empty ? 32'h0 : in_head;
            REG_MBOX_STAT: rd_data = mbox_stat;
            default:       rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scratch_q   <= '0;
            ctrl_q      <= CTRL_RESET;
            rsp_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_en && reg_idx == REG_SCRATCH) scratch_q <= csr_req_i.data;
            if (wr_en && reg_idx == REG_CTRL)    ctrl_q    <= csr_req_i.data;
            if (rd_en)                           rsp_q     <= rd_data;
            // Setting a sticky flag wins over a simultaneous write-1-to-clear.
            overflow_q  <= overflow_set  | (overflow_q  & ~(stat_wr & csr_req_i.data[16]));
            underflow_q <= underflow_set | (underflow_q & ~(stat_wr & csr_req_i.data[17]));
            irq_q       <= (in_count_next != '0);
        end
    end

    assign csr_rsp_valid_o  = (state_q == RESP);
    assign csr_rsp_o.data   = rsp_q;
    assign ctrl_o           = ctrl_q;
    assign mbox_out_data_o  = out_head;
    assign mbox_out_valid_o = ~out_empty;
    assign mbox_in_ready_o  = ~in_full;
    assign irq_o            = irq_q;
endmodule

// File: tb/tb_hemaia_csr_regbank.sv
// Bench for hemaia_csr_regbank: register vector table, directed mailbox/handshake sequences,
// and randomized traffic checked every cycle against a queue-based model of the register map.
module tb_hemaia_csr_regbank;
    localparam int          D        = 4;
    localparam logic [31:0] CTRL_RST = 32'hC0DE_0001;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        write;
    } req_t;

    typedef struct packed {
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          write;
        logic [31:0] status;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    req_t        req;
    logic        req_valid;
    logic        req_ready;
    rsp_t        rsp;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] ctrl;
    logic [31:0] status;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        irq;

    int passed = 0;
    int total  = 0;

    // Reference model of the architectural state.
    logic [31:0] m_scratch, m_ctrl, m_rsp;
    bit          m_busy, m_ovf, m_udf, m_irq;
    logic [31:0] m_out[$];
    logic [31:0] m_in[$];

    hemaia_csr_regbank #(
        .ADDR_WIDTH (32),
        .MBOX_DEPTH (D),
        .CTRL_RESET (CTRL_RST),
        .csr_req_t  (req_t),
        .csr_rsp_t  (rsp_t)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .csr_req_i        (req),
        .csr_req_valid_i  (req_valid),
        .csr_req_ready_o  (req_ready),
        .csr_rsp_o        (rsp),
        .csr_rsp_valid_o  (rsp_valid),
        .csr_rsp_ready_i  (rsp_ready),
        .ctrl_o           (ctrl),
        .status_i         (status),
        .mbox_out_data_o  (out_data),
        .mbox_out_valid_o (out_valid),
        .mbox_out_ready_i (out_ready),
        .mbox_in_data_i   (in_data),
        .mbox_in_valid_i  (in_valid),
        .mbox_in_ready_o  (in_ready),
        .irq_o            (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic m_reset();
        m_scratch = '0;
        m_ctrl    = CTRL_RST;
        m_rsp     = '0;
        m_busy    = 0;
        m_ovf     = 0;
        m_udf     = 0;
        m_irq     = 0;
        m_out.delete();
        m_in.delete();
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[4:2])
            3'd0:    return m_scratch;
            3'd1:    return m_ctrl;
            3'd2:    return status;
            3'd3:    return (m_in.size() != 0) ? m_in[0] : 32'h0;
            3'd4:    return {14'd0, m_udf, m_ovf, 8'(m_in.size()), 8'(m_out.size())};
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic m_step();
        int          osz = m_out.size();
        int          isz = m_in.size();
        logic [31:0] rdv = m_read(req.addr);
        bit          hw_push = in_valid && (isz < D);
        if (out_ready && osz > 0) void'(m_out.pop_front());
        if (!m_busy && req_valid && req.write) begin
            case (req.addr[4:2])
                3'd0: m_scratch = req.data;
                3'd1: m_ctrl = req.data;
                3'd3: begin
                    if (osz == D) m_ovf = 1;
                    else m_out.push_back(req.data);
                end
                3'd4: begin
                    if (req.data[16]) m_ovf = 0;
                    if (req.data[17]) m_udf = 0;
                end
                default: ;
            endcase
        end else if (!m_busy && req_valid) begin
            m_rsp  = rdv;
            m_busy = 1;
            if (req.addr[4:2] == 3'd3) begin
                if (isz > 0) void'(m_in.pop_front());
                else m_udf = 1;
            end
        end else if (m_busy && req_valid && rsp_ready) begin
            m_busy = 0;
        end
        if (hw_push) m_in.push_back(in_data);
        m_irq = (m_in.size() != 0);
    endtask

    // Called at a falling edge with inputs set: check outputs, clock once, return at next falling edge.
    task automatic cycle();
        #1;
        chk("rsp_valid", rsp_valid, m_busy);
        if (m_busy) chk("rsp_data", rsp.data, m_rsp);
        chk("req_ready", req_ready, m_busy ? rsp_ready : (req_valid & req.write));
        chk("ctrl", ctrl, m_ctrl);
        chk("out_valid", out_valid, m_out.size() != 0);
        if (m_out.size() != 0) chk("out_data", out_data, m_out[0]);
        chk("in_ready", in_ready, m_in.size() < D);
        chk("irq", irq, m_irq);
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        req.addr  = a;
        req.data  = v;
        req.write = 1'b1;
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        int n = 0;
        req.addr  = a;
        req.data  = $urandom;
        req.write = 1'b0;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        cycle();
        while (!rsp_valid && n < 4) begin
            cycle();
            n++;
        end
        if (!rsp_valid) begin
            total++;
            $display("FAIL rd_timeout: no response for addr %h, got valid %b, expected 1", a, rsp_valid);
            d = 'x;
        end else begin
            d = rsp.data;
            cycle();
        end
        req_valid = 1'b0;
    endtask

    initial begin : main
        vec_t        tbl[16];
        logic [31:0] d;
        logic [31:0] a;

        tbl[0]  = '{32'h00, 32'hA5A5_1234, 1'b1, 32'h0,         32'h0};
        tbl[1]  = '{32'h00, 32'h0,         1'b0, 32'h0,         32'hA5A5_1234};
        tbl[2]  = '{32'h04, 32'h0,         1'b0, 32'h0,         CTRL_RST};
        tbl[3]  = '{32'h07, 32'h1234_5678, 1'b1, 32'h0,         32'h0};
        tbl[4]  = '{32'h24, 32'h0,         1'b0, 32'h0,         32'h1234_5678};
        tbl[5]  = '{32'h08, 32'h0,         1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[6]  = '{32'h14, 32'hFFFF_FFFF, 1'b1, 32'h0,         32'h0};
        tbl[7]  = '{32'h14, 32'h0,         1'b0, 32'h0,         32'h0};
        tbl[8]  = '{32'h1C, 32'h0,         1'b0, 32'h0,         32'h0};
        tbl[9]  = '{32'h08, 32'h5555_5555, 1'b1, 32'h0,         32'h0};
        tbl[10] = '{32'h08, 32'h0,         1'b0, 32'h0000_0042, 32'h0000_0042};
        tbl[11] = '{32'h00, 32'h0,         1'b0, 32'h0,         32'hA5A5_1234};
        tbl[12] = '{32'h0C, 32'h0,         1'b0, 32'h0,         32'h0};
        tbl[13] = '{32'h10, 32'h0,         1'b0, 32'h0,         32'h0002_0000};
        tbl[14] = '{32'h10, 32'h0002_0000, 1'b1, 32'h0,         32'h0};
        tbl[15] = '{32'h10, 32'h0,         1'b0, 32'h0,         32'h0};

        rst       = 1'b1;
        req       = '0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        status    = '0;
        out_ready = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp.data, 32'h0);
        chk("rst_ctrl", ctrl, CTRL_RST);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_irq", irq, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            status = tbl[i].status;
            if (tbl[i].write) begin
                wr(tbl[i].addr, tbl[i].data);
            end else begin
                rd(tbl[i].addr, d);
                chk($sformatf("vec%0d_rd", i), d, tbl[i].exp);
            end
        end

        // Write-then-read timing on SCRATCH.
        req.addr = 32'h00; req.data = 32'hA5A5_1234; req.write = 1'b1; req_valid = 1'b1;
        #1 chk("a_wr_ready", req_ready, 1'b1);
        cycle();
        req.write = 1'b0;
        #1 chk("a_rd_ready_idle", req_ready, 1'b0);
        chk("a_rd_valid_idle", rsp_valid, 1'b0);
        cycle();
        chk("a_rd_valid", rsp_valid, 1'b1);
        chk("a_rd_data", rsp.data, 32'hA5A5_1234);
        cycle();
        req_valid = 1'b0;

        // STATUS read held by response backpressure while status_i keeps moving.
        status = 32'h1111_1111;
        req.addr = 32'h08; req.write = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
        cycle();
        for (int k = 0; k < 3; k++) begin
            status = $urandom;
            chk("b_hold_valid", rsp_valid, 1'b1);
            chk("b_hold_data", rsp.data, 32'h1111_1111);
            chk("b_hold_req_ready", req_ready, 1'b0);
            cycle();
        end
        rsp_ready = 1'b1;
        #1 chk("b_release_req_ready", req_ready, 1'b1);
        cycle();
        req_valid = 1'b0;
        chk("b_done_valid", rsp_valid, 1'b0);

        // Outbound overflow, W1C, then ordered drain.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(32'h0C, 32'h100 + i);
        rd(32'h10, d);
        chk("c_stat_full", d, 32'h0001_0004);
        wr(32'h10, 32'h0001_0000);
        rd(32'h10, d);
        chk("c_stat_cleared", d, 32'h0000_0004);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("c_drain_valid", out_valid, 1'b1);
            chk("c_drain_data", out_data, 32'h100 + i);
            cycle();
        end
        chk("c_drained", out_valid, 1'b0);
        out_ready = 1'b0;

        // Inbound messages, interrupt, underflow.
        in_valid = 1'b1;
        in_data = 32'h11; cycle();
        in_data = 32'h22; cycle();
        in_valid = 1'b0;
        chk("d_irq_set", irq, 1'b1);
        rd(32'h0C, d); chk("d_pop0", d, 32'h11);
        chk("d_irq_one_left", irq, 1'b1);
        rd(32'h0C, d); chk("d_pop1", d, 32'h22);
        chk("d_irq_clear", irq, 1'b0);
        rd(32'h0C, d); chk("d_pop_empty", d, 32'h0);
        rd(32'h10, d); chk("d_stat_udf", d, 32'h0002_0000);
        wr(32'h10, 32'h0002_0000);

        // Full inbound FIFO: host pop and refused hw push in the same cycle.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hA0 + i;
            cycle();
        end
        chk("e_full", in_ready, 1'b0);
        in_data = 32'hBB;
        req.addr = 32'h0C; req.write = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
        #1 chk("e_ready_before", in_ready, 1'b0);
        cycle();
        in_valid = 1'b0;
        chk("e_ready_after", in_ready, 1'b1);
        chk("e_rsp_valid", rsp_valid, 1'b1);
        chk("e_rsp_data", rsp.data, 32'hA0);
        cycle();
        req_valid = 1'b0;
        rd(32'h10, d); chk("e_stat_count", d, 32'h0000_0300);
        for (int i = 1; i < 4; i++) begin
            rd(32'h0C, d);
            chk("e_pop", d, 32'hA0 + i);
        end
        rd(32'h0C, d); chk("e_no_bb", d, 32'h0);
        wr(32'h10, 32'h0002_0000);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if (!m_busy) begin
                a = $urandom;
                a[4:2] = ($urandom_range(0, 1) == 1) ? 3'd3 : 3'($urandom_range(0, 7));
                req.addr  = a;
                req.data  = $urandom;
                req.write = 1'($urandom_range(0, 1));
                req_valid = ($urandom_range(0, 3) != 0);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            status    = $urandom;
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        if (m_busy) begin
            rsp_ready = 1'b1;
            cycle();
        end
        req_valid = 1'b0;

        // Asynchronous reset while a read response is pending.
        wr(32'h04, 32'h0BAD_F00D);
        in_valid = 1'b1; in_data = 32'h77;
        cycle();
        in_valid = 1'b0;
        req.addr = 32'h0C; req.write = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
        cycle();
        chk("f_in_resp", rsp_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("f_rst_rsp_valid", rsp_valid, 1'b0);
        chk("f_rst_rsp_data", rsp.data, 32'h0);
        chk("f_rst_req_ready", req_ready, 1'b0);
        chk("f_rst_ctrl", ctrl, CTRL_RST);
        chk("f_rst_out_valid", out_valid, 1'b0);
        chk("f_rst_in_ready", in_ready, 1'b1);
        chk("f_rst_irq", irq, 1'b0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd(32'h18, d); chk("f_unmapped", d, 32'h0);
        rd(32'h10, d); chk("f_stat", d, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
